// File: rtl/ysyx_22050535_ifu_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// default widths, reset PC and the NOP used for misaligned fetches.
package ysyx_22050535_ifu_pkg;

    localparam int          IFU_ADDR_WIDTH = 32;
    localparam int          IFU_INST_WIDTH = 32;
    localparam logic [31:0] IFU_RESET_PC   = 32'h8000_0000;
    localparam logic [31:0] IFU_NOP        = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } ifu_state_t;

endpackage

// File: rtl/ysyx_22050535_ifu_fetch.sv
// Multi-cycle instruction fetch: owns the PC, issues one imem request at a
// time and hands each instruction to decode over a valid/ready handshake.
//
// state | meaning
// REQ   | PC valid, requesting memory (or trapping a misaligned PC)
// WAIT  | request accepted, waiting for the single-cycle response
// HOLD  | instruction presented to decode until it is accepted
module ysyx_22050535_ifu_fetch
    import ysyx_22050535_ifu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = IFU_ADDR_WIDTH,
    parameter int                    INST_WIDTH = IFU_INST_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(IFU_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [ADDR_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INST_WIDTH-1:0] imem_rsp_data,
    input  logic                  imem_rsp_err,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc,
    output logic                  out_err
);

    ifu_state_t            state_q, state_d;
    logic                  drop_q, drop_d;
    logic                  armed_q;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  valid_q, valid_d;
    logic [INST_WIDTH-1:0] inst_q, inst_d;
    logic [ADDR_WIDTH-1:0] opc_q, opc_d;
    logic                  err_q, err_d;
    logic                  misaligned;
    logic                  req_valid;
    logic                  req_fire;

    // armed_q keeps the request channel quiet until the first edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_REQ;
            drop_q  <= 1'b0;
            armed_q <= 1'b0;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            inst_q  <= '0;
            opc_q   <= RESET_PC;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            armed_q <= 1'b1;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            inst_q  <= inst_d;
            opc_q   <= opc_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        drop_d     = drop_q;
        pc_d       = pc_q;
        valid_d    = valid_q;
        inst_d     = inst_q;
        opc_d      = opc_q;
        err_d      = err_q;
        misaligned = (pc_q[1:0] != 2'b00);
        req_valid  = armed_q && (state_q == ST_REQ) && !misaligned;
        req_fire   = req_valid && imem_req_ready;

        if (redirect_valid) begin
            pc_d = redirect_pc;
            unique case (state_q)
                ST_REQ: begin
                    if (req_fire) begin
                        state_d = ST_WAIT;
                        drop_d  = 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = ST_REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    valid_d = 1'b0;
                    state_d = ST_REQ;
                end
                default: state_d = ST_REQ;
            endcase
        end else begin
            unique case (state_q)
                ST_REQ: begin
                    if (misaligned) begin
                        state_d = ST_HOLD;
                        valid_d = 1'b1;
                        inst_d  = INST_WIDTH'(IFU_NOP);
                        opc_d   = pc_q;
                        err_d   = 1'b1;
                    end else if (req_fire) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (imem_rsp_valid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = ST_REQ;
                        end else begin
                            state_d = ST_HOLD;
                            valid_d = 1'b1;
                            inst_d  = imem_rsp_data;
                            opc_d   = pc_q;
                            err_d   = imem_rsp_err;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        pc_d    = pc_q + ADDR_WIDTH'(4);
                        valid_d = 1'b0;
                        state_d = ST_REQ;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    assign imem_req_valid = req_valid;
    assign imem_req_addr  = pc_q;
    assign out_valid      = valid_q;
    assign out_inst       = inst_q;
    assign out_pc         = opc_q;
    assign out_err        = err_q;

endmodule

// File: tb/tb_ysyx_22050535_ifu_fetch.sv
// Directed bench for the fetch stage: a transaction-level reference model,
// a simple latency-programmable memory and per-cycle output comparison.
module tb_ysyx_22050535_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        imem_rsp_err = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_err;

    int checks = 0;
    int failures = 0;

    ysyx_22050535_ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_err        (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: tracks the PC, whether a request is outstanding
    // (and whether it was squashed) and the item held for decode.
    logic [31:0] m_pc;
    bit          m_armed, m_out, m_squash, m_have, m_fire;
    logic [31:0] m_inst, m_ipc;
    logic        m_err;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = 32'h8000_0000; m_armed = 0; m_out = 0; m_squash = 0; m_have = 0;
        end else begin
            m_fire = m_armed && !m_have && !m_out && (m_pc % 4 == 0) && imem_req_ready;
            if (redirect_valid) begin
                if (m_out) begin
                    if (imem_rsp_valid) begin m_out = 0; m_squash = 0; end
                    else m_squash = 1;
                end else if (m_fire) begin
                    m_out = 1; m_squash = 1;
                end
                m_have = 0;
                m_pc = redirect_pc;
            end else if (m_have) begin
                if (out_ready) begin m_have = 0; m_pc = m_pc + 4; end
            end else if (m_out) begin
                if (imem_rsp_valid) begin
                    m_out = 0;
                    if (!m_squash) begin
                        m_have = 1; m_inst = imem_rsp_data; m_ipc = m_pc; m_err = imem_rsp_err;
                    end
                    m_squash = 0;
                end
            end else if (m_pc % 4 != 0) begin
                m_have = 1; m_inst = 32'h0000_0013; m_ipc = m_pc; m_err = 1'b1;
            end else if (m_fire) begin
                m_out = 1;
            end
            m_armed = 1;
        end
    end

    always @(negedge clk) begin
        chk("req_valid", 32'(imem_req_valid),
            32'(m_armed && !m_have && !m_out && (m_pc % 4 == 0)));
        if (m_armed && !m_have && !m_out && (m_pc % 4 == 0))
            chk("req_addr", imem_req_addr, m_pc);
        chk("out_valid", 32'(out_valid), 32'(m_have));
        if (m_have) begin
            chk("out_inst", out_inst, m_inst);
            chk("out_pc", out_pc, m_ipc);
            chk("out_err", 32'(out_err), 32'(m_err));
        end
    end

    // Memory: responds a programmable number of cycles after acceptance.
    int          lat = 1;
    int          mem_cnt = 0;
    logic [31:0] mem_data = 32'h0000_0093;
    logic        mem_err = 1'b0;

    always @(negedge clk) begin
        #2;
        imem_rsp_valid = 1'b0;
        if (!rst) begin
            mem_cnt = 0;
        end else begin
            if (mem_cnt > 0) begin
                mem_cnt--;
                if (mem_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_data;
                    imem_rsp_err   = mem_err;
                end
            end
            if (imem_req_valid && imem_req_ready) mem_cnt = lat;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_out_valid(input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = out_valid;
        end
        chk({name, "_timeout"}, 32'(seen), 32'd1);
    endtask

    logic [31:0] held;

    initial begin
        tick(); tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        rst = 1'b1;

        // first fetch, 1-cycle memory
        tick();
        chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_req_addr", imem_req_addr, 32'h8000_0000);
        tick();
        chk("t1_lat_n1", 32'(out_valid), 32'd0);
        tick();
        chk("t1_lat_n2", 32'(out_valid), 32'd1);
        chk("t1_pc", out_pc, 32'h8000_0000);
        chk("t1_inst", out_inst, 32'h0000_0093);
        chk("t1_err", 32'(out_err), 32'd0);

        // decode stalls for 5 cycles
        held = out_inst;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t2_hold_valid", 32'(out_valid), 32'd1);
            chk("t2_hold_inst", out_inst, held);
            chk("t2_no_req", 32'(imem_req_valid), 32'd0);
        end
        out_ready = 1'b1; lat = 3; mem_data = 32'h0000_0073;
        tick();
        out_ready = 1'b0;
        chk("t2_next_addr", imem_req_addr, 32'h8000_0004);

        // redirect while waiting; stale response must be dropped
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        tick();
        redirect_valid = 1'b0;
        tick();
        chk("t3_stale_no_valid", 32'(out_valid), 32'd0);
        tick();
        chk("t3_stale_no_valid2", 32'(out_valid), 32'd0);
        chk("t3_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t3_req_addr", imem_req_addr, 32'h8000_0100);
        lat = 1; mem_data = 32'h0010_0093;
        wait_out_valid("t3");
        chk("t3_pc", out_pc, 32'h8000_0100);
        chk("t3_inst", out_inst, 32'h0010_0093);

        // redirect coinciding with handshake beats pc+4
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        tick();
        out_ready = 1'b0;
        chk("t4_out_valid", 32'(out_valid), 32'd0);
        chk("t4_req_addr", imem_req_addr, 32'h8000_0100);
        // redirect to a misaligned PC while the request is not accepted
        imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        chk("t5_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        chk("t5_valid", 32'(out_valid), 32'd1);
        chk("t5_inst", out_inst, 32'h0000_0013);
        chk("t5_err", 32'(out_err), 32'd1);
        chk("t5_pc", out_pc, 32'h8000_0102);

        // access fault on the response
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
        mem_err = 1'b1; mem_data = 32'hdead_beef;
        tick();
        out_ready = 1'b0; redirect_valid = 1'b0;
        chk("t6_req_addr", imem_req_addr, 32'h8000_0200);
        wait_out_valid("t6");
        chk("t6_err", 32'(out_err), 32'd1);
        chk("t6_inst", out_inst, 32'hdead_beef);
        chk("t6_pc", out_pc, 32'h8000_0200);
        out_ready = 1'b1; mem_err = 1'b0; lat = 3;
        tick();
        out_ready = 1'b0;
        chk("t6_next_addr", imem_req_addr, 32'h8000_0204);

        // reset pulse while waiting
        tick();
        #3 rst = 1'b0;
        #1;
        chk("t7_rst_out_valid", 32'(out_valid), 32'd0);
        chk("t7_rst_inst", out_inst, 32'h0);
        chk("t7_rst_err", 32'(out_err), 32'd0);
        chk("t7_rst_req_valid", 32'(imem_req_valid), 32'd0);
        lat = 1; mem_data = 32'h0000_0093;
        tick(); tick();
        rst = 1'b1;
        tick();
        chk("t7_refetch_addr", imem_req_addr, 32'h8000_0000);
        chk("t7_refetch_valid", 32'(imem_req_valid), 32'd1);
        wait_out_valid("t7");
        chk("t7_pc", out_pc, 32'h8000_0000);

        // PC wraps past the top of the address space
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hffff_fffc;
        tick();
        out_ready = 1'b0; redirect_valid = 1'b0;
        chk("t8_req_addr", imem_req_addr, 32'hffff_fffc);
        wait_out_valid("t8");
        chk("t8_pc", out_pc, 32'hffff_fffc);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t8_wrap_addr", imem_req_addr, 32'h0000_0000);
        tick(); tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22050535_ifu_fetch.md
Name: ysyx_22050535_ifu_fetch

Overview:
Multi-cycle instruction fetch stage sitting directly upstream of the decode stage.
- Owns the architectural PC.
- Issues one request at a time to the instruction memory over a valid/ready request channel and a valid-only response channel.
- Presents each fetched instruction, its PC and an error flag to decode through a valid/ready handshake.
- Accepts PC redirects from the execute stage (branches and jumps) and squashes any in-flight fetch.

Parameters:
ADDR_WIDTH, 32, PC and memory address width
INST_WIDTH, 32, instruction word width
RESET_PC, 32'h8000_0000, PC value loaded on reset

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
redirect_valid  input  1  execute stage requests a PC change this cycle
redirect_pc  input  ADDR_WIDTH  new PC, valid when redirect_valid=1
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts the request
imem_req_addr  output  ADDR_WIDTH  fetch address (current PC)
imem_rsp_valid  input  1  response valid, single-cycle pulse
imem_rsp_data  input  INST_WIDTH  fetched instruction
imem_rsp_err  input  1  access fault for this response
out_valid  output  1  instruction available to decode
out_ready  input  1  decode accepts the instruction
out_inst  output  INST_WIDTH  instruction to decode
out_pc  output  ADDR_WIDTH  PC of out_inst
out_err  output  1  fetch fault or misaligned PC

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=REQ, drop=0.
  - out_valid=0, out_inst=0, out_err=0.
  - imem_req_valid=0 while rst=0; it asserts from the first clock edge after release.
- States: REQ, WAIT, HOLD, plus a 1-bit drop flag. At most one outstanding request.
- REQ:
  - If pc[1:0]!=0: no memory access; next state HOLD with out_inst=32'h0000_0013 (NOP) and out_err=1.
  - Otherwise imem_req_valid=1 and imem_req_addr=pc; on imem_req_ready=1, next state WAIT.
- WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid with drop=1: discard the response, clear drop, go to REQ.
  - On imem_rsp_valid with drop=0: latch out_inst=imem_rsp_data, out_err=imem_rsp_err, out_pc=pc; go to HOLD.
- HOLD:
  - out_valid=1; out_inst, out_pc and out_err stay stable until the handshake completes.
  - On out_ready=1: pc<=pc+4 (modulo 2^ADDR_WIDTH, wraps silently), go to REQ.
- out_valid is a registered output and is asserted only in HOLD.
- Minimum latency: request accepted in cycle N, response in N+1, out_valid in N+2. Peak throughput is one instruction per 3 cycles.
- Redirect has priority over every other event in the same cycle and always sets pc<=redirect_pc:
  - REQ, request not accepted: stay in REQ. imem_req_addr changes next cycle; this is legal on this channel.
  - REQ, request accepted in the same cycle: go to WAIT with drop=1.
  - WAIT, no response: drop<=1.
  - WAIT, response in the same cycle: discard the response, drop<=0, go to REQ.
  - HOLD: out_valid<=0, go to REQ, whatever the value of out_ready. Decode must also squash; the stage does not check this.
- imem_rsp_valid outside WAIT is a protocol violation: ignore it, no state change.
- Reset asserted mid-transaction: return to the reset state immediately. A pending memory response after release is ignored under the rule above; the memory model must not emit one.

Decomposition:
- Shared package: state encoding (REQ/WAIT/HOLD), RESET_PC, INST_WIDTH/ADDR_WIDTH defaults, the NOP constant 32'h0000_0013.
- No sub-module required. The pc+4 / redirect mux may be factored into ysyx_22050535_pc_next, but that is optional.

Test Plan:
- Release reset, memory ready=1, 1-cycle latency, data 32'h00000093 -> request addr 8000_0000; out_valid 2 cycles after the request is accepted; out_pc=8000_0000, out_inst=0000_0093, out_err=0; next request addr 8000_0004.
- out_ready held 0 for 5 cycles in HOLD -> out_valid stays 1 and outputs stay stable; no new request; on out_ready=1 the next request goes to 8000_0004.
- Redirect to 8000_0100 while in WAIT; stale response 0000_0073 arrives -> response discarded, no out_valid; next request addr 8000_0100.
- Redirect in the same cycle as HOLD handshake (out_ready=1) -> pc=8000_0100, not +4; next request addr 8000_0100.
- Redirect to 8000_0102 -> no memory request; out_valid with out_inst=0000_0013, out_err=1, out_pc=8000_0102.
- imem_rsp_err=1 on response -> out_err=1 with the returned data; reset pulse asserted in WAIT -> outputs clear immediately; refetch from 8000_0000.
